load_use_scoreboard: RTL and testbench

//  Parametrised load-use hazard unit for the RV32I pipeline, supporting variable-latency data memory.

---
 rtl/load_use_scoreboard_if.sv | 30 +++
 rtl/load_use_scoreboard.sv | 152 +++++++++++++++
 tb/tb_load_use_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/load_use_scoreboard_if.sv
// Issue/response bundle between decode and the load-use scoreboard.
// The master drives issue and memory-response inputs; the slave returns hazard state.
interface load_use_scoreboard_if #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                iss_valid;
    logic [31:0]         iss_instr;
    logic                flush;
    logic                ld_resp_valid;
    logic                stall;
    logic [NUM_REGS-1:0] busy_vec;
    logic [PTR_W:0]      pending_cnt;
    logic                full;
    logic [CNT_W-1:0]    stall_cycles;
    logic                err_underflow;

    modport master (
        output iss_valid, iss_instr, flush, ld_resp_valid,
        input  stall, busy_vec, pending_cnt, full, stall_cycles, err_underflow
    );

    modport slave (
        input  iss_valid, iss_instr, flush, ld_resp_valid,
        output stall, busy_vec, pending_cnt, full, stall_cycles, err_underflow
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: in-order FIFO of outstanding load destinations, a busy vector
// derived from it, and the issue stall that keeps dependents waiting for load data.
module load_use_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit RESP_BYPASS     = 1'b1,
    parameter int CNT_W           = 16
) (
    input logic                 clk,
    input logic                 rst,
    load_use_scoreboard_if.slave bus
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Decode of the instruction attempting issue
    logic [6:0]       opcode;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             uses_rs1, uses_rs2, is_load;

    assign opcode   = bus.iss_instr[6:0];
    assign rs1      = bus.iss_instr[15 +: REG_W];
    assign rs2      = bus.iss_instr[20 +: REG_W];
    assign rd       = bus.iss_instr[7 +: REG_W];
    assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) && (bus.iss_instr != NOP_INSTR);
    assign uses_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    assign is_load  = (opcode == OPC_LOAD);

    // Tag FIFO state
    logic [REG_W-1:0]           entry_rd [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] entry_valid;
    logic [PTR_W-1:0]           head, tail;
    logic [PTR_W:0]             count;
    logic [NUM_REGS-1:0]        busy_vec;
    logic [CNT_W-1:0]           stall_cycles;
    logic                       err_underflow;

    logic empty, full;
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(MAX_OUTSTANDING));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A head register shared by a younger entry must stay busy through the bypass
    logic [REG_W-1:0] head_rd;
    logic             head_dup;

    assign head_rd = entry_rd[head];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        head_dup = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (PTR_W'(i) != head && entry_valid[i] && entry_rd[i] == head_rd)
                head_dup = 1'b1;
        end
    end

    logic [NUM_REGS-1:0] busy_eff;

    always_comb begin
        busy_eff = busy_vec;
        if (RESP_BYPASS && bus.ld_resp_valid && !empty && !head_dup)
            busy_eff[head_rd] = 1'b0;
        busy_eff[0] = 1'b0;
    end

    // Hazard evaluation and FIFO handshakes
    logic raw, struc, stall, push, pop, underflow;

    assign raw       = (uses_rs1 && busy_eff[rs1]) || (uses_rs2 && busy_eff[rs2]);
    assign struc     = is_load && (rd != '0) && full && !bus.ld_resp_valid;
    assign stall     = bus.iss_valid && !bus.flush && (raw || struc);
    assign push      = bus.iss_valid && !bus.flush && !stall && is_load && (rd != '0);
    assign pop       = bus.ld_resp_valid && !empty;
    assign underflow = bus.ld_resp_valid && empty;

    // Post-update FIFO view, so busy_vec reflects this cycle's push and pop
    logic [MAX_OUTSTANDING-1:0] valid_nxt;
    logic [REG_W-1:0]           rd_nxt [MAX_OUTSTANDING];
    logic [NUM_REGS-1:0]        busy_nxt;

    always_comb begin
        valid_nxt = entry_valid;
        rd_nxt    = entry_rd;
        if (pop)
            valid_nxt[head] = 1'b0;
        // Push after pop: a full FIFO reuses the slot the head just vacated
        if (push) begin
            valid_nxt[tail] = 1'b1;
            rd_nxt[tail]    = rd;
        end
        busy_nxt = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (valid_nxt[i])
                busy_nxt[rd_nxt[i]] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            entry_valid   <= '0;
            busy_vec      <= '0;
            stall_cycles  <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop)
                head <= ptr_inc(head);
            if (push)
                tail <= ptr_inc(tail);
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            entry_valid <= valid_nxt;
            busy_vec    <= busy_nxt;
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

    // NOTE: the rd storage array is not reset; entry_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push)
            entry_rd[tail] <= rd;
    end

    assign bus.stall         = stall;
    assign bus.busy_vec      = busy_vec;
    assign bus.pending_cnt   = count;
    assign bus.full          = full;
    assign bus.stall_cycles  = stall_cycles;
    assign bus.err_underflow = err_underflow;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: vector table through a scoreboard queue,
// then stall-counter saturation and a mid-stream asynchronous reset.
module tb_load_use_scoreboard;
    localparam int NUM_REGS = 32;
    localparam int MAX_OUT  = 4;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_use_scoreboard_if #(.NUM_REGS(NUM_REGS), .MAX_OUTSTANDING(MAX_OUT), .CNT_W(CNT_W)) bus();

    load_use_scoreboard #(
        .NUM_REGS(NUM_REGS), .MAX_OUTSTANDING(MAX_OUT), .RESP_BYPASS(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string       name;
        logic        iss_valid;
        logic [31:0] instr;
        logic        flush;
        logic        resp;
        logic        exp_stall;
        int          exp_cnt;
        logic [31:0] exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_sc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic v, input logic [31:0] ins,
                                input logic fl, input logic rs, input logic es,
                                input int ec, input logic [31:0] eb, input logic ee);
        vec_t r;
        r.name = nm; r.iss_valid = v; r.instr = ins; r.flush = fl; r.resp = rs;
        r.exp_stall = es; r.exp_cnt = ec; r.exp_busy = eb; r.exp_err = ee;
        return r;
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    // Drive one cycle; stall is checked mid-cycle, registered state after the edge
    task automatic step(input vec_t v);
        vec_t e;
        bus.iss_valid     = v.iss_valid;
        bus.iss_instr     = v.instr;
        bus.flush         = v.flush;
        bus.ld_resp_valid = v.resp;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check({e.name, " stall"}, 32'(bus.stall), 32'(e.exp_stall));
        if (e.exp_stall && exp_sc < (2**CNT_W - 1))
            exp_sc++;
        @(posedge clk);
        #1;
        check({e.name, " pending_cnt"}, 32'(bus.pending_cnt), 32'(e.exp_cnt));
        check({e.name, " busy_vec"}, bus.busy_vec, e.exp_busy);
        check({e.name, " full"}, 32'(bus.full), 32'(e.exp_cnt == MAX_OUT));
        check({e.name, " err_underflow"}, 32'(bus.err_underflow), 32'(e.exp_err));
        check({e.name, " stall_cycles"}, 32'(bus.stall_cycles), 32'(exp_sc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lui_x5, jal_x5, slli_x9, sw_x5, beq_x5;
        lui_x5  = {12'h000, 5'd5, 3'b000, 5'd5, 7'b0110111};
        jal_x5  = {12'h000, 5'd5, 3'b000, 5'd5, 7'b1101111};
        slli_x9 = {7'd0, 5'd2, 5'd5, 3'b001, 5'd9, 7'b0010011};
        sw_x5   = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
        beq_x5  = {7'd0, 5'd5, 5'd1, 3'b000, 5'd0, 7'b1100011};

        //                name           v   instr              fl  rs  stall cnt busy      err
        vecs.push_back(mk("idle",        0, 32'h0,              0,  0,  0,    0, 32'h0,    0));
        vecs.push_back(mk("lw_x5",       1, lw(5, 1),           0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("add_dep1",    1, add(6, 5, 7),       0,  0,  1,    1, 32'h20,   0));
        vecs.push_back(mk("add_dep2",    1, add(6, 5, 7),       0,  0,  1,    1, 32'h20,   0));
        vecs.push_back(mk("add_bypass",  1, add(6, 5, 7),       0,  1,  0,    0, 32'h0,    0));
        vecs.push_back(mk("lw_x5_b",     1, lw(5, 1),           0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("lui_x5",      1, lui_x5,             0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("jal_x5",      1, jal_x5,             0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("addi_imm5",   1, addi(9, 1, 12'd5),  0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("addi_imm3",   1, addi(9, 1, 12'd3),  0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("nop",         1, 32'h13,             0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("slli_rs1",    1, slli_x9,            0,  0,  1,    1, 32'h20,   0));
        vecs.push_back(mk("sw_rs2",      1, sw_x5,              0,  0,  1,    1, 32'h20,   0));
        vecs.push_back(mk("beq_rs2",     1, beq_x5,             0,  0,  1,    1, 32'h20,   0));
        vecs.push_back(mk("resp_only",   0, 32'h0,              0,  1,  0,    0, 32'h0,    0));
        vecs.push_back(mk("fill_x1",     1, lw(1, 10),          0,  0,  0,    1, 32'h2,    0));
        vecs.push_back(mk("fill_x2",     1, lw(2, 10),          0,  0,  0,    2, 32'h6,    0));
        vecs.push_back(mk("fill_x3",     1, lw(3, 10),          0,  0,  0,    3, 32'hE,    0));
        vecs.push_back(mk("fill_x4",     1, lw(4, 10),          0,  0,  0,    4, 32'h1E,   0));
        vecs.push_back(mk("lw_x8_full",  1, lw(8, 10),          0,  0,  1,    4, 32'h1E,   0));
        vecs.push_back(mk("lw_x8_pop",   1, lw(8, 10),          0,  1,  0,    4, 32'h11C,  0));
        vecs.push_back(mk("head_x2",     1, add(9, 2, 0),       0,  1,  0,    3, 32'h118,  0));
        vecs.push_back(mk("x3_busy",     1, add(9, 3, 0),       0,  0,  1,    3, 32'h118,  0));
        vecs.push_back(mk("drain3",      0, 32'h0,              0,  1,  0,    2, 32'h110,  0));
        vecs.push_back(mk("drain2",      0, 32'h0,              0,  1,  0,    1, 32'h100,  0));
        vecs.push_back(mk("drain1",      0, 32'h0,              0,  1,  0,    0, 32'h0,    0));
        vecs.push_back(mk("dup_x5_a",    1, lw(5, 1),           0,  0,  0,    1, 32'h20,   0));
        vecs.push_back(mk("dup_x5_b",    1, lw(5, 1),           0,  0,  0,    2, 32'h20,   0));
        vecs.push_back(mk("dup_resp1",   1, add(6, 5, 0),       0,  1,  1,    1, 32'h20,   0));
        vecs.push_back(mk("dup_resp2",   0, 32'h0,              0,  1,  0,    0, 32'h0,    0));
        vecs.push_back(mk("lw_x0",       1, lw(0, 1),           0,  0,  0,    0, 32'h0,    0));
        vecs.push_back(mk("underflow",   0, 32'h0,              0,  1,  0,    0, 32'h0,    1));
        vecs.push_back(mk("lw_x5_c",     1, lw(5, 1),           0,  0,  0,    1, 32'h20,   1));
        vecs.push_back(mk("flush_haz",   1, lw(7, 5),           1,  0,  0,    1, 32'h20,   1));
        vecs.push_back(mk("noflush_haz", 1, lw(7, 5),           0,  0,  1,    1, 32'h20,   1));
        vecs.push_back(mk("resp_c",      0, 32'h0,              0,  1,  0,    0, 32'h0,    1));
        vecs.push_back(mk("empty_push",  1, lw(6, 1),           0,  1,  0,    1, 32'h40,   1));
        vecs.push_back(mk("resp_d",      0, 32'h0,              0,  1,  0,    0, 32'h0,    1));

        bus.iss_valid = 1'b0; bus.iss_instr = 32'h0; bus.flush = 1'b0; bus.ld_resp_valid = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset stall", 32'(bus.stall), 32'd0);
        check("reset pending_cnt", 32'(bus.pending_cnt), 32'd0);
        check("reset busy_vec", bus.busy_vec, 32'd0);
        check("reset full", 32'(bus.full), 32'd0);
        check("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check("reset err_underflow", 32'(bus.err_underflow), 32'd0);

        foreach (vecs[i]) step(vecs[i]);

        // Stall counter saturation across a long load-use hazard
        step(mk("sat_lw", 1, lw(5, 1), 0, 0, 0, 1, 32'h20, 1));
        for (int i = 0; i < 20; i++)
            step(mk("sat_stall", 1, add(6, 5, 0), 0, 0, 1, 1, 32'h20, 1));
        check("sat stall_cycles", 32'(bus.stall_cycles), 32'hF);
        step(mk("sat_resp", 0, 32'h0, 0, 1, 0, 0, 32'h0, 1));

        // Asynchronous reset with three loads outstanding
        step(mk("pre_rst_1", 1, lw(1, 10), 0, 0, 0, 1, 32'h2, 1));
        step(mk("pre_rst_2", 1, lw(2, 10), 0, 0, 0, 2, 32'h6, 1));
        step(mk("pre_rst_3", 1, lw(3, 10), 0, 0, 0, 3, 32'hE, 1));
        bus.iss_valid = 1'b0; bus.ld_resp_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst pending_cnt", 32'(bus.pending_cnt), 32'd0);
        check("async_rst busy_vec", bus.busy_vec, 32'd0);
        check("async_rst full", 32'(bus.full), 32'd0);
        check("async_rst stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check("async_rst err_underflow", 32'(bus.err_underflow), 32'd0);
        #2 rst = 1'b0;
        exp_sc = 0;
        @(posedge clk);
        #1;
        step(mk("post_rst_lw", 1, lw(5, 1), 0, 0, 0, 1, 32'h20, 0));
        step(mk("post_rst_dep", 1, add(6, 5, 0), 0, 0, 1, 1, 32'h20, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
